// File: rtl/rib_pkg.sv
// Shared RIB interconnect constants: FSM encodings, error read data and width helpers.
// Imported by the crossbar and its arbiter.
package rib_pkg;

    localparam logic [0:0] RIB_ST_IDLE = 1'b0;
    localparam logic [0:0] RIB_ST_BUSY = 1'b1;

    localparam logic [31:0] RIB_ERR_DATA = 32'h0000_0000;

    function automatic int rib_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Timeout counter must represent TIMEOUT itself so it can saturate there.
    function automatic int rib_cnt_w(input int tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/rib_rr_arbiter.sv
// Combinational request picker: round-robin from rr_ptr, or fixed priority (index 0 wins).
// Zero latency; grant is all-zero when nothing requests.
module rib_rr_arbiter
    import rib_pkg::*;
#(
    parameter int NUM_M = 4,
    parameter bit RR_EN = 1'b1,
    localparam int IW   = rib_idx_w(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [NUM_M-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] base;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        base    = RR_EN ? rr_ptr : '0;
        for (int k = 0; k < NUM_M; k++) begin
            // rr_ptr < NUM_M, so one conditional subtract is enough to wrap.
            sum = {1'b0, base} + (IW+1)'(k);
            if (sum >= (IW+1)'(NUM_M)) begin
                sum = sum - (IW+1)'(NUM_M);
            end
            cand = sum[IW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_xbar.sv
// NUM_M masters share one registered-arbitration path to NUM_S slaves; min 2 cycles req->ack.
// Non-granted masters see hold_flag until acked; decode errors and timeouts complete with m_err.
module rib_xbar
    import rib_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int NUM_S   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_W   = 4,
    parameter bit RR_EN   = 1'b1,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_M-1:0]      m_req,
    input  logic [NUM_M-1:0]      m_we,
    input  logic [NUM_M*AW-1:0]   m_addr,
    input  logic [NUM_M*DW-1:0]   m_wdata,
    output logic [NUM_M*DW-1:0]   m_rdata,
    output logic [NUM_M-1:0]      m_ack,
    output logic [NUM_M-1:0]      m_err,
    output logic [NUM_M-1:0]      hold_flag,
    output logic [NUM_S-1:0]      s_req,
    output logic [NUM_S-1:0]      s_we,
    output logic [NUM_S*AW-1:0]   s_addr,
    output logic [NUM_S*DW-1:0]   s_wdata,
    input  logic [NUM_S*DW-1:0]   s_rdata,
    input  logic [NUM_S-1:0]      s_ack
);

    localparam int IW       = rib_idx_w(NUM_M);
    localparam int TW       = rib_cnt_w(TIMEOUT);
    localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int TMO_SAT  = (TIMEOUT > 0) ? TIMEOUT : 1;

    logic [0:0]    state_q,   state_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic [IW-1:0] rr_ptr_q,  rr_ptr_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic [NUM_M-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;

    rib_rr_arbiter #(
        .NUM_M (NUM_M),
        .RR_EN (RR_EN)
    ) u_arb (
        .req     (m_req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    logic             cur_req;
    logic             cur_we;
    logic [AW-1:0]    cur_addr;
    logic [DW-1:0]    cur_wdata;
    logic [SEL_W-1:0] sel;
    logic             dec_ok;
    logic             s_ack_sel;
    logic [DW-1:0]    s_rdata_sel;

    always_comb begin
        cur_req   = 1'b0;
        cur_we    = 1'b0;
        cur_addr  = '0;
        cur_wdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_idx_q == IW'(i)) begin
                cur_req   = m_req[i];
                cur_we    = m_we[i];
                cur_addr  = m_addr[i*AW +: AW];
                cur_wdata = m_wdata[i*DW +: DW];
            end
        end
        sel    = cur_addr[AW-1 -: SEL_W];
        dec_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_S));
        s_ack_sel   = 1'b0;
        s_rdata_sel = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (sel == SEL_W'(j)) begin
                s_ack_sel   = s_ack[j];
                s_rdata_sel = s_rdata[j*DW +: DW];
            end
        end
    end

    logic live;
    logic s_go;
    logic tmo_hit;
    logic ack_ok;
    logic ack_err;
    logic any_ack;

    // Gating with rst means a transaction interrupted by reset never acks.
    assign live    = rst && (state_q == RIB_ST_BUSY) && cur_req;
    assign s_go    = live && dec_ok;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TW'(TMO_LAST));
    assign ack_ok  = s_go && s_ack_sel;
    assign ack_err = live && (!dec_ok || (!s_ack_sel && tmo_hit));
    assign any_ack = ack_ok || ack_err;

    always_comb begin
        s_req   = '0;
        s_we    = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (s_go && (sel == SEL_W'(j))) begin
                s_req[j]              = 1'b1;
                s_we[j]               = cur_we;
                s_addr[j*AW +: AW]    = {{SEL_W{1'b0}}, cur_addr[AW-SEL_W-1:0]};
                s_wdata[j*DW +: DW]   = cur_wdata;
            end
        end
    end

    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_rdata = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (gnt_idx_q == IW'(i)) begin
                m_ack[i]            = any_ack;
                m_err[i]            = ack_err;
                m_rdata[i*DW +: DW] = ack_ok ? s_rdata_sel : DW'(RIB_ERR_DATA);
            end
        end
    end

    assign hold_flag = m_req & ~m_ack;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        rr_ptr_d  = rr_ptr_q;
        tmo_cnt_d = tmo_cnt_q;
        case (state_q)
            RIB_ST_IDLE: begin
                tmo_cnt_d = '0;
                if (|arb_gnt) begin
                    state_d   = RIB_ST_BUSY;
                    gnt_idx_d = arb_idx;
                end
            end
            RIB_ST_BUSY: begin
                if (!cur_req) begin
                    // Master withdrew without an ack: drop it, keep fairness pointer.
                    state_d = RIB_ST_IDLE;
                end else if (any_ack) begin
                    state_d  = RIB_ST_IDLE;
                    rr_ptr_d = (gnt_idx_q == IW'(NUM_M - 1)) ? '0 : gnt_idx_q + IW'(1);
                end else if (tmo_cnt_q != TW'(TMO_SAT)) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: state_d = RIB_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RIB_ST_IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_rib_xbar.sv
// Bench for rib_xbar: a round-robin and a fixed-priority instance share master stimulus;
// acks of the round-robin instance are checked against a scoreboard queue.
module tb_rib_xbar;

    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM-1:0]   m_req, m_we;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]   ack_mask;

    logic [NM*DW-1:0] m_rdata_rr, m_rdata_fp;
    logic [NM-1:0]    m_ack_rr, m_err_rr, hold_rr, m_ack_fp, m_err_fp, hold_fp;
    logic [NS-1:0]    s_req_rr, s_we_rr, s_ack_rr, s_req_fp, s_we_fp, s_ack_fp;
    logic [NS*AW-1:0] s_addr_rr, s_addr_fp;
    logic [NS*DW-1:0] s_wdata_rr, s_wdata_fp;

    // Zero-wait slaves, individually silenced through ack_mask.
    assign s_ack_rr = s_req_rr & ack_mask;
    assign s_ack_fp = s_req_fp & ack_mask;

    always #5 clk = ~clk;

    rib_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(4), .RR_EN(1'b1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata_rr), .m_ack(m_ack_rr), .m_err(m_err_rr), .hold_flag(hold_rr),
        .s_req(s_req_rr), .s_we(s_we_rr), .s_addr(s_addr_rr), .s_wdata(s_wdata_rr),
        .s_rdata(s_rdata), .s_ack(s_ack_rr));

    rib_xbar #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .SEL_W(4), .RR_EN(1'b0), .TIMEOUT(8)) dut_fp (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata_fp), .m_ack(m_ack_fp), .m_err(m_err_fp), .hold_flag(hold_fp),
        .s_req(s_req_fp), .s_we(s_we_fp), .s_addr(s_addr_fp), .s_wdata(s_wdata_fp),
        .s_rdata(s_rdata), .s_ack(s_ack_fp));

    typedef struct packed {
        logic [1:0]  m;
        logic        err;
        logic [31:0] rdata;
    } sb_t;

    typedef struct packed {
        logic [1:0]  m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        s_vld;
        logic [1:0]  slv;
        logic [31:0] saddr;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    sb_t  exp_q[$];
    sb_t  mon_e;
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic mon_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en && (m_ack_rr != '0)) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ack", 128'(m_ack_rr), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_ack_master", 128'(m_ack_rr), 128'(4'b0001 << mon_e.m));
                chk("sb_err", 128'(m_err_rr), mon_e.err ? 128'(4'b0001 << mon_e.m) : 128'(0));
                chk("sb_rdata", 128'(m_rdata_rr), 128'(mon_e.rdata) << (mon_e.m * DW));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          got;
        int          ack_cyc[5];
        logic [3:0]  e4;
        logic [3:0]  e_ack;
        logic [3:0]  e_sreq;

        vecs[0] = '{m:2'd1, we:1'b0, addr:32'h1000_0010, wdata:32'h0,         s_vld:1'b1, slv:2'd1, saddr:32'h0000_0010, err:1'b0, rdata:32'hDEAD_BEEF};
        vecs[1] = '{m:2'd0, we:1'b1, addr:32'h0000_0100, wdata:32'hA5A5_0001, s_vld:1'b1, slv:2'd0, saddr:32'h0000_0100, err:1'b0, rdata:32'h1111_0000};
        vecs[2] = '{m:2'd2, we:1'b0, addr:32'h3FFF_FFFC, wdata:32'h0,         s_vld:1'b1, slv:2'd3, saddr:32'h0FFF_FFFC, err:1'b0, rdata:32'h3333_3333};
        vecs[3] = '{m:2'd3, we:1'b1, addr:32'h2123_4567, wdata:32'h0000_005A, s_vld:1'b1, slv:2'd2, saddr:32'h0123_4567, err:1'b0, rdata:32'h2222_2222};
        vecs[4] = '{m:2'd1, we:1'b0, addr:32'hF000_0000, wdata:32'h0,         s_vld:1'b0, slv:2'd0, saddr:32'h0,         err:1'b1, rdata:32'h0};
        vecs[5] = '{m:2'd3, we:1'b1, addr:32'h4000_0000, wdata:32'h0000_1234, s_vld:1'b0, slv:2'd0, saddr:32'h0,         err:1'b1, rdata:32'h0};
        vecs[6] = '{m:2'd2, we:1'b1, addr:32'h3000_0000, wdata:32'hCAFE_F00D, s_vld:1'b1, slv:2'd3, saddr:32'h0,         err:1'b0, rdata:32'h3333_3333};

        rst      = 1'b0;
        mon_en   = 1'b1;
        m_req    = 4'b1111;
        m_we     = 4'b0000;
        m_addr   = {32'h0000_000C, 32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
        m_wdata  = {32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'h4444_0000};
        s_rdata  = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_0000};
        ack_mask = 4'b1111;

        // Reset with every master requesting, then round-robin over slave 0.
        for (int i = 0; i < 5; i++) exp_q.push_back('{m:2'(i), err:1'b0, rdata:32'h1111_0000});
        @(posedge clk);
        smp();
        chk("rst_sreq_rr", 128'(s_req_rr), 128'(0));
        chk("rst_ack_rr", 128'(m_ack_rr), 128'(0));
        chk("rst_hold_rr", 128'(hold_rr), 128'(4'b1111));
        chk("rst_sreq_fp", 128'(s_req_fp), 128'(0));
        chk("rst_hold_fp", 128'(hold_fp), 128'(4'b1111));
        chk("rst_rdata_rr", 128'(m_rdata_rr), 128'(0));
        tick();
        rst = 1'b1;
        got = 0;
        for (int c = 0; c < 24 && got < 5; c++) begin
            smp();
            if (m_ack_rr != '0) begin
                ack_cyc[got] = cyc;
                got++;
            end
            tick();
        end
        m_req = 4'b0000;
        chk("rr_ack_count", 128'(got), 128'(5));
        for (int i = 0; i < 4; i++) chk("rr_ack_spacing", 128'(ack_cyc[i+1] - ack_cyc[i]), 128'(2));
        tick();
        tick();
        chk("rr_sb_drain", 128'(exp_q.size()), 128'(0));

        // Masters 0 and 2 contend: fixed priority keeps serving 0, round-robin alternates.
        mon_en = 1'b0;
        m_req  = 4'b0101;
        smp();
        chk("fp_idle_ack", 128'(m_ack_fp), 128'(0));
        chk("fp_idle_hold", 128'(hold_fp), 128'(4'b0101));
        tick(); smp();
        chk("fp_ack1", 128'(m_ack_fp), 128'(4'b0001));
        chk("fp_hold1", 128'(hold_fp), 128'(4'b0100));
        chk("rr_alt_ack1", 128'(m_ack_rr), 128'(4'b0100));
        tick(); smp();
        chk("fp_gap_ack", 128'(m_ack_fp), 128'(0));
        tick(); smp();
        chk("fp_ack2", 128'(m_ack_fp), 128'(4'b0001));
        chk("rr_alt_ack2", 128'(m_ack_rr), 128'(4'b0001));
        tick();
        m_req = 4'b0100;
        smp();
        chk("fp_m2_hold", 128'(hold_fp), 128'(4'b0100));
        tick(); smp();
        chk("fp_ack_m2", 128'(m_ack_fp), 128'(4'b0100));
        tick();
        m_req = 4'b0000;
        tick();
        tick();
        mon_en = 1'b1;

        // Single-master decode vectors, including out-of-range slave selects.
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{m:vecs[i].m, err:vecs[i].err, rdata:vecs[i].rdata});
            m_addr  = {32'h3000_0300, 32'h2000_0200, 32'h1000_0100, 32'h0000_0000};
            m_wdata = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
            m_addr[vecs[i].m*AW +: AW]  = vecs[i].addr;
            m_wdata[vecs[i].m*DW +: DW] = vecs[i].wdata;
            e4    = 4'b0001 << vecs[i].m;
            m_we  = vecs[i].we ? e4 : ~e4;
            m_req = e4;
            smp();
            chk("vec_idle_sreq", 128'(s_req_rr), 128'(0));
            chk("vec_idle_hold", 128'(hold_rr), 128'(e4));
            tick(); smp();
            e_sreq = vecs[i].s_vld ? (4'b0001 << vecs[i].slv) : 4'b0000;
            chk("vec_sreq", 128'(s_req_rr), 128'(e_sreq));
            chk("vec_swe", 128'(s_we_rr), vecs[i].we ? 128'(e_sreq) : 128'(0));
            chk("vec_saddr", 128'(s_addr_rr), vecs[i].s_vld ? (128'(vecs[i].saddr) << (vecs[i].slv * AW)) : 128'(0));
            chk("vec_swdata", 128'(s_wdata_rr), vecs[i].s_vld ? (128'(vecs[i].wdata) << (vecs[i].slv * DW)) : 128'(0));
            chk("vec_ack_time", 128'(m_ack_rr), 128'(e4));
            chk("vec_busy_hold", 128'(hold_rr), 128'(0));
            tick();
            m_req = 4'b0000;
            tick();
        end
        chk("vec_sb_drain", 128'(exp_q.size()), 128'(0));

        // Silent slave 0: error ack on the 9th cycle, then the waiting master 1 is served.
        m_addr   = {32'h0000_000C, 32'h0000_0008, 32'h1000_0004, 32'h0000_0008};
        m_we     = 4'b0000;
        ack_mask = 4'b0010;
        exp_q.push_back('{m:2'd0, err:1'b1, rdata:32'h0});
        exp_q.push_back('{m:2'd1, err:1'b0, rdata:32'hDEAD_BEEF});
        for (int c = 1; c <= 11; c++) begin
            if (c == 1)  m_req = 4'b0001;
            if (c == 2)  m_req = 4'b0011;
            if (c == 10) m_req = 4'b0010;
            smp();
            e_ack  = (c == 9) ? 4'b0001 : (c == 11) ? 4'b0010 : 4'b0000;
            e_sreq = (c >= 2 && c <= 9) ? 4'b0001 : (c == 11) ? 4'b0010 : 4'b0000;
            chk("tmo_ack", 128'(m_ack_rr), 128'(e_ack));
            chk("tmo_sreq", 128'(s_req_rr), 128'(e_sreq));
            tick();
        end
        m_req = 4'b0000;
        tick();
        chk("tmo_sb_drain", 128'(exp_q.size()), 128'(0));

        // Reset while BUSY with the slave acking: the transaction must vanish.
        ack_mask = 4'b0000;
        m_req    = 4'b0001;
        smp();
        chk("abort_idle_sreq", 128'(s_req_rr), 128'(0));
        tick(); smp();
        chk("abort_busy_sreq", 128'(s_req_rr), 128'(4'b0001));
        tick();
        rst      = 1'b0;
        ack_mask = 4'b1111;
        smp();
        chk("abort_ack", 128'(m_ack_rr), 128'(0));
        chk("abort_hold", 128'(hold_rr), 128'(4'b0001));
        chk("abort_sreq", 128'(s_req_rr), 128'(0));
        tick();
        rst   = 1'b1;
        m_req = 4'b0000;
        smp();
        chk("abort_post_sreq", 128'(s_req_rr), 128'(0));
        tick(); smp();
        chk("abort_post_ack", 128'(m_ack_rr), 128'(0));
        chk("abort_sb_drain", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
